instruction_decode_register: RTL
================================

Name: instruction_decode_register

Overview:
- Pipeline register between instruction fetch and the immediate-extension stage.
- Accepts 32-bit instructions over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Splits each instruction into fields and presents the raw immediate plus the extension-mode flag U (1 = zero-extend, 0 = sign-extend), which drive the extender's U and immediateIN inputs directly.
- Also counts retired decodes.

Parameters:
- IW, 32, instruction width; fixed layout opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
- N, 16, immediate field width; taken from instr[N-1:0]; legal range 1..16.
- CW, 16, width of the decode counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  buffer can accept; registered.
- instrIN  in  IW  instruction word.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- opcode  out  6  instr[31:26] of head entry.
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- immediateOUT  out  N  instr[N-1:0], raw and unextended.
- U  out  1  extension mode for the downstream extender.
- decodeCount  out  CW  number of completed output handshakes.

Behaviour:
- Reset (rst_n=0 at posedge):
  - out_valid=0, in_ready=0, opcode/rs/rt/immediateOUT/U=0, decodeCount=0, state=EMPTY.
  - in_ready becomes 1 on the first edge with rst_n=1.
  - A reset asserted mid-operation discards both entries identically.
- Accept and release:
  - Accept when in_valid&in_ready.
  - Release when out_valid&out_ready.
- U decode, computed at accept time and stored with the entry:
  - U=1 for opcode 0x0C (ANDI), 0x0D (ORI), 0x0E (XORI), 0x0F (LUI).
  - U=0 for all other opcodes.
- State machine, head = main register, second = skid register:
  - EMPTY: accept -> ONE, entry loaded into main.
  - ONE:
    - accept without release -> TWO, entry loaded into skid, in_ready=0 next cycle.
    - release without accept -> EMPTY.
    - accept and release together -> ONE, new entry loaded into main.
    - neither -> ONE.
  - TWO (in_ready=0, so no accept):
    - release -> ONE, skid moves to main, in_ready=1 next cycle.
    - otherwise hold.
- Latency: one cycle from accept to out_valid when the buffer is EMPTY.
- Throughput: one instruction per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, all head fields hold stable.
- Ordering: strict FIFO order.
- flush=1 (synchronous):
  - Next state EMPTY, out_valid=0, in_ready=1.
  - Flush has priority over a same-cycle accept; that instruction is dropped.
  - A same-cycle release still completes: the downstream sampled it, so decodeCount increments.
- decodeCount:
  - Increments by 1 per release.
  - Wraps from 2^CW-1 to 0 with no saturation and no flag.
- Registered fields for an empty slot keep their last values; consumers qualify them with out_valid.

Optional Feature:
- Macro IDR_ILLEGAL_OP_EN.
- When defined:
  - Adds output port illegalOp (1 bit).
  - illegalOp=1 alongside a head entry whose opcode is outside {0x00, 0x02–0x0F, 0x20–0x2B}.
  - Such entries still flow normally and are counted.
  - illegalOp resets to 0, and reads 0 whenever out_valid=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then single pass-through:
   - Stimulus: hold rst_n=0 for 3 cycles; send instrIN=0x3C1F8000 (LUI) with out_ready=1.
   - Response: out_valid one cycle later; opcode=0x0F, rs=0x00, rt=0x1F, immediateOUT=0x8000, U=1; decodeCount=1.
2. Sign mode:
   - Stimulus: instrIN=0x21098000 (opcode 0x08).
   - Response: U=0, immediateOUT=0x8000, rs=0x08, rt=0x09.
3. Backpressure:
   - Stimulus: out_ready=0; stream A=0x31AA7FFF, B=0x21BB0001, C.
   - Response: in_ready falls after B and C is not accepted; A holds stable at the output.
   - Stimulus: raise out_ready.
   - Response: A then B appear on consecutive cycles; in_ready returns the cycle after A releases.
4. Flush collision:
   - Stimulus: state TWO, assert flush together with out_ready=1.
   - Response: head counted (decodeCount+1); next cycle out_valid=0 and in_ready=1; skid entry never appears.
5. Counter wrap:
   - Stimulus: CW=4, perform 17 releases.
   - Response: decodeCount=1.
6. Reset mid-stream:
   - Stimulus: pull rst_n low while in state TWO.
   - Response: out_valid=0, decodeCount=0, in_ready=0 during reset; in_ready=1 one cycle after release.
   - With IDR_ILLEGAL_OP_EN: opcode 0x3F yields illegalOp=1 with out_valid=1.

Source files
------------

// File: rtl/instruction_decode_register_if.sv
// Fetch-to-extend handshake bundle for instruction_decode_register.
// The illegalOp signal exists only when IDR_ILLEGAL_OP_EN is defined.
interface instruction_decode_register_if #(
  parameter int IW = 32,
  parameter int N  = 16,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] instrIN;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [N-1:0]  immediateOUT;
  logic          U;
  logic [CW-1:0] decodeCount;
`ifdef IDR_ILLEGAL_OP_EN
  logic          illegalOp;

  modport slave (
    input  in_valid, instrIN, out_ready,
    output in_ready, out_valid, opcode, rs, rt, immediateOUT, U, decodeCount, illegalOp
  );
  modport master (
    output in_valid, instrIN, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, immediateOUT, U, decodeCount, illegalOp
  );
`else
  modport slave (
    input  in_valid, instrIN, out_ready,
    output in_ready, out_valid, opcode, rs, rt, immediateOUT, U, decodeCount
  );
  modport master (
    output in_valid, instrIN, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, immediateOUT, U, decodeCount
  );
`endif
endinterface

// File: rtl/instruction_decode_register.sv
// Two-entry skid buffer between fetch and immediate extension; decodes fields,
// extension mode U and counts releases. Optional illegalOp flag: IDR_ILLEGAL_OP_EN.
module instruction_decode_register #(
  parameter int IW = 32,
  parameter int N  = 16,
  parameter int CW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  instruction_decode_register_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          u;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        main_q, skid_q, in_entry;
  logic          in_ready_q, in_ready_d;
  logic [CW-1:0] cnt_q;
  logic          acc, rel;
  logic          ld_main_in, ld_main_skid, ld_skid;

  // Logical-immediate opcodes 0x0C..0x0F zero-extend.
  assign in_entry.instr = bus.instrIN;
  assign in_entry.u     = (bus.instrIN[31:28] == 4'b0011);

  assign acc = bus.in_valid & in_ready_q;
  assign rel = (state_q != EMPTY) & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      EMPTY: if (acc) begin
        state_d    = ONE;
        ld_main_in = 1'b1;
      end
      ONE: begin
        if (acc && !rel) begin
          state_d = TWO;
          ld_skid = 1'b1;
        end else if (!acc && rel) begin
          state_d = EMPTY;
        end else if (acc && rel) begin
          ld_main_in = 1'b1;
        end
      end
      TWO: if (rel) begin
        state_d      = ONE;
        ld_main_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops any same-cycle accept; a same-cycle release still counts.
    if (flush) begin
      state_d      = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_entry;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_entry;
      if (rel)               cnt_q  <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    bus.in_ready     = in_ready_q;
    bus.out_valid    = (state_q != EMPTY);
    bus.opcode       = main_q.instr[31:26];
    bus.rs           = main_q.instr[25:21];
    bus.rt           = main_q.instr[20:16];
    bus.immediateOUT = main_q.instr[N-1:0];
    bus.U            = main_q.u;
    bus.decodeCount  = cnt_q;
  end

`ifdef IDR_ILLEGAL_OP_EN
  logic [5:0] hop;
  logic       legal;
  always_comb begin
    hop          = main_q.instr[31:26];
    legal        = (hop == 6'h00) || (hop >= 6'h02 && hop <= 6'h0F) ||
                   (hop >= 6'h20 && hop <= 6'h2B);
    bus.illegalOp = (state_q != EMPTY) && !legal;
  end
`endif

endmodule
